// File: rtl/jk_ctrl_pkg.sv
// rtl/jk_ctrl_pkg.sv - shared op encodings and FSM state type for the JK bank controller
// Purpose: one place for the command opcodes and controller states used by
//          jk_counter_sequencer and its testbench.
// Ports:   none (package).
package jk_ctrl_pkg;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_CLEAR   = 3'd1;
    localparam logic [2:0] OP_LOAD    = 3'd2;
    localparam logic [2:0] OP_UP_N    = 3'd3;
    localparam logic [2:0] OP_DOWN_N  = 3'd4;
    localparam logic [2:0] OP_FREE_UP = 3'd5;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_COUNT = 2'd3
    } state_e;

endpackage

// File: rtl/jk_toggle_map.sv
// rtl/jk_toggle_map.sv - per-bit toggle mask and wrap prediction for a JK up/down counter
// Purpose: given the current bank value and a direction, produce which cells
//          must toggle for one count step and whether that step wraps.
// Ports:
//   i_q         in   WIDTH  current bank value (q outputs)
//   i_dir       in   1      0 = count up, 1 = count down
//   o_toggle    out  WIDTH  T mask; bit i set means cell i toggles this step
//   o_wrap_next out  1      the step from i_q wraps (all-ones up, zero down)
module jk_toggle_map #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_toggle,
    output logic             o_wrap_next
);

    logic [WIDTH-1:0] w_src;

    // Counting down is counting up on the inverted value, so one carry chain
    // serves both directions.
    assign w_src = i_dir ? ~i_q : i_q;

    always_comb begin
        logic v_carry;
        v_carry  = 1'b1;
        o_toggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_toggle[i] = v_carry;
            v_carry     = v_carry & w_src[i];
        end
        // Carry out of the top bit means every bit toggles: the step wraps.
        o_wrap_next = v_carry;
    end

endmodule

// File: rtl/jk_counter_sequencer.sv
// rtl/jk_counter_sequencer.sv - command-driven controller for an external bank of JK flip-flops
// Purpose: accepts clear / load / count-N / free-run commands and drives the
//          J/K pins of a WIDTH-cell JK bank, reading its state back on q_in.
//          The bank has no reset of its own; this block clears it after reset.
// Ports:
//   clk        in   1       clock shared with the JK bank
//   rst        in   1       asynchronous active-high reset
//   cmd_valid  in   1       command present
//   cmd_ready  out  1       command can be accepted (IDLE)
//   cmd_op     in   3       opcode, see jk_ctrl_pkg; 6-7 behave as NOP
//   cmd_arg    in   STEP_W  LOAD value (low WIDTH bits) or step count N
//   step_en    in   1       count tick
//   abort      in   1       terminate a COUNT immediately
//   q_in       in   WIDTH   bank q outputs
//   j_out      out  WIDTH   bank J inputs
//   k_out      out  WIDTH   bank K inputs
//   busy       out  1       not IDLE
//   done       out  1       one-cycle completion pulse
//   wrap       out  1       one-cycle pulse after a wrapping step
//   steps_left out  STEP_W  remaining steps of UP_N/DOWN_N
module jk_counter_sequencer
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic              step_en,
    input  logic              abort,
    input  logic [WIDTH-1:0]  q_in,
    output logic [WIDTH-1:0]  j_out,
    output logic [WIDTH-1:0]  k_out,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [STEP_W-1:0] ONE_STEP = STEP_W'(1);

    state_e            r_state;
    logic [2:0]        r_op;
    logic [WIDTH-1:0]  r_arg;
    logic              r_dir;
    logic              r_free;
    logic [STEP_W-1:0] r_steps_left;
    logic              r_done;
    logic              r_wrap;

    state_e            w_state_next;
    logic [STEP_W-1:0] w_steps_next;
    logic              w_done_next;
    logic              w_wrap_next;
    logic              w_accept;
    logic [WIDTH-1:0]  w_toggle;
    logic              w_step_wraps;

    jk_toggle_map #(
        .WIDTH (WIDTH)
    ) u_toggle_map (
        .i_q         (q_in),
        .i_dir       (r_dir),
        .o_toggle    (w_toggle),
        .o_wrap_next (w_step_wraps)
    );

    assign w_accept   = cmd_valid && (r_state == ST_IDLE);
    assign cmd_ready  = (r_state == ST_IDLE);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign wrap       = r_wrap;
    assign steps_left = r_steps_left;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_op         <= OP_NOP;
            r_arg        <= '0;
            r_dir        <= 1'b0;
            r_free       <= 1'b0;
            r_steps_left <= '0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_steps_left <= w_steps_next;
            r_done       <= w_done_next;
            r_wrap       <= w_wrap_next;
            if (w_accept) begin
                r_op   <= cmd_op;
                r_arg  <= cmd_arg[WIDTH-1:0];
                r_dir  <= (cmd_op == OP_DOWN_N);
                r_free <= (cmd_op == OP_FREE_UP);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_steps_next = r_steps_left;
        w_done_next  = 1'b0;
        w_wrap_next  = 1'b0;
        j_out        = '0;
        k_out        = '0;

        case (r_state)
            // Reset state is INIT, so the bank is being cleared for as long
            // as rst is held, plus the one edge after it drops.
            ST_INIT: begin
                k_out        = '1;
                w_state_next = ST_IDLE;
            end

            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        OP_CLEAR, OP_LOAD: begin
                            w_state_next = ST_EXEC;
                        end
                        OP_UP_N, OP_DOWN_N: begin
                            if (cmd_arg != '0) begin
                                w_state_next = ST_COUNT;
                                w_steps_next = cmd_arg;
                            end else begin
                                w_done_next = 1'b1;
                            end
                        end
                        OP_FREE_UP: begin
                            w_state_next = ST_COUNT;
                            w_steps_next = '0;
                        end
                        default: begin
                            w_done_next = 1'b1;
                        end
                    endcase
                end
            end

            ST_EXEC: begin
                if (r_op == OP_LOAD) begin
                    j_out = r_arg;
                    k_out = ~r_arg;
                end else begin
                    k_out = '1;
                end
                w_state_next = ST_IDLE;
                w_done_next  = 1'b1;
            end

            ST_COUNT: begin
                // abort beats step_en: no toggle, no done, count discarded.
                if (abort) begin
                    w_state_next = ST_IDLE;
                    w_steps_next = '0;
                end else if (step_en) begin
                    j_out       = w_toggle;
                    k_out       = w_toggle;
                    w_wrap_next = w_step_wraps;
                    if (!r_free) begin
                        w_steps_next = r_steps_left - ONE_STEP;
                        if (r_steps_left == ONE_STEP) begin
                            w_state_next = ST_IDLE;
                            w_done_next  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_jk_counter_sequencer.sv
// tb/tb_jk_counter_sequencer.sv - self-checking bench for jk_counter_sequencer with a 4-cell JK bank
module tb_jk_counter_sequencer;
    import jk_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg;
    logic       step_en;
    logic       abort;
    logic [3:0] q_bank;
    logic [3:0] j_out;
    logic [3:0] k_out;
    logic       busy;
    logic       done;
    logic       wrap;
    logic [7:0] steps_left;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jk_counter_sequencer #(
        .WIDTH  (4),
        .STEP_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .step_en    (step_en),
        .abort      (abort),
        .q_in       (q_bank),
        .j_out      (j_out),
        .k_out      (k_out),
        .busy       (busy),
        .done       (done),
        .wrap       (wrap),
        .steps_left (steps_left)
    );

    // Four JK cells, no reset.
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            case ({j_out[b], k_out[b]})
                2'b10:   q_bank[b] <= 1'b1;
                2'b01:   q_bank[b] <= 1'b0;
                2'b11:   q_bank[b] <= ~q_bank[b];
                default: q_bank[b] <= q_bank[b];
            endcase
        end
    end

    typedef struct {
        logic       v;
        logic [2:0] op;
        logic [7:0] arg;
        logic       se;
        logic       ab;
        logic [3:0] q;
        logic       done;
        logic       wrap;
        logic       busy;
        logic [7:0] sl;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic v, logic [2:0] op, logic [7:0] arg, logic se, logic ab,
                                logic [3:0] q, logic dn, logic wr, logic bz, logic [7:0] sl);
        vec_t r;
        r.v = v; r.op = op; r.arg = arg; r.se = se; r.ab = ab;
        r.q = q; r.done = dn; r.wrap = wr; r.busy = bz; r.sl = sl;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
        step_en   = 1'b0;
        abort     = 1'b0;

        // Reset: bank is cleared while rst is held; one INIT cycle after release.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("init_ready", 32'(cmd_ready), 32'd0);
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_k", 32'(k_out), 32'hF);
        tick();
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_q", 32'(q_bank), 32'h0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_steps", 32'(steps_left), 32'd0);

        //                v  op  arg    se ab   q     dn wr bz sl
        tbl.push_back(mk(1, 2, 8'h0A, 0, 0, 4'h0, 0, 0, 1, 0));   // LOAD 0xA
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hA, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hA, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 8'h07, 1, 0, 4'hA, 0, 0, 1, 7));   // UP_N 7
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hB, 0, 0, 1, 6));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hC, 0, 0, 1, 5));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hD, 0, 0, 1, 4));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hE, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hF, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h0, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4, 8'h03, 0, 0, 4'h1, 0, 0, 1, 3));   // DOWN_N 3
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h1, 0, 0, 1, 3));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hF, 0, 1, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'hF, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'hE, 1, 0, 0, 0));
        tbl.push_back(mk(1, 1, 8'h00, 0, 0, 4'hE, 0, 0, 1, 0));   // CLEAR
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 8'h09, 0, 0, 4'h0, 0, 0, 1, 0));   // FREE_UP
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h2, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h3, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h4, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 4'h5, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 4'h5, 0, 0, 0, 0));   // abort + step_en
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 3, 8'h00, 1, 0, 4'h5, 1, 0, 0, 0));   // UP_N 0
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 8'h33, 1, 0, 4'h5, 1, 0, 0, 0));   // op 7
        tbl.push_back(mk(0, 0, 8'h00, 0, 0, 4'h5, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 8'hF6, 0, 1, 4'h5, 0, 0, 1, 0));   // LOAD, abort ignored
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 4'h6, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 8'h05, 0, 0, 4'h6, 0, 0, 1, 5));   // UP_N 5, then reset

        for (int i = 0; i < tbl.size(); i++) begin
            cmd_valid = tbl[i].v;
            cmd_op    = tbl[i].op;
            cmd_arg   = tbl[i].arg;
            step_en   = tbl[i].se;
            abort     = tbl[i].ab;
            tick();
            chk($sformatf("row%0d_q", i), 32'(q_bank), 32'(tbl[i].q));
            chk($sformatf("row%0d_done", i), 32'(done), 32'(tbl[i].done));
            chk($sformatf("row%0d_wrap", i), 32'(wrap), 32'(tbl[i].wrap));
            chk($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("row%0d_ready", i), 32'(cmd_ready), 32'(!tbl[i].busy));
            chk($sformatf("row%0d_steps", i), 32'(steps_left), 32'(tbl[i].sl));
        end

        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
        step_en   = 1'b1;
        abort     = 1'b0;

        // Reset mid UP_N: outputs respond without waiting for a clock edge.
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd1);
        chk("midrst_ready", 32'(cmd_ready), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_steps", 32'(steps_left), 32'd0);
        chk("midrst_j", 32'(j_out), 32'h0);
        chk("midrst_k", 32'(k_out), 32'hF);
        chk("midrst_q_before", 32'(q_bank), 32'h6);
        tick();
        chk("midrst_q_cleared", 32'(q_bank), 32'h0);
        chk("midrst_done2", 32'(done), 32'd0);
        rst     = 1'b0;
        step_en = 1'b0;
        tick();
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        chk("post_rst_q", 32'(q_bank), 32'h0);
        chk("post_rst_done", 32'(done), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
